exu_bjp_cmt: RTL and testbench
==============================

// Module: exu_bjp_cmt
// PURPOSE
//  Branch/jump commit stage directly downstream of the BJP ALU path in the EXU.
//  Accepts one resolved branch/jump per handshake, compares actual direction against
//  the fetch-time prediction, and on mismatch issues a registered redirect/flush request
//  to the IFU. New commits are held off until the flush completes and a fixed drain
//  window expires. Also keeps saturating branch and mispredict counters for perf/debug.
// PARAMETERS
//  PC_SIZE    32  width of PC and redirect target
//  DRAIN_CYC  2   cycles to block commits after flush accepted (0 = none)
//  CNT_W      32  width of each perf counter
// PORTS
//  clk             in   1        clock, all state on rising edge
//  rst             in   1        synchronous reset, active-high
//  cmt_i_valid     in   1        commit request from BJP ALU
//  cmt_i_ready     out  1        stage can accept a commit
//  cmt_i_bjp       in   1        request is a branch/jump (0 = ordinary, pass-through)
//  cmt_i_bprdt     in   1        predicted taken at fetch
//  cmt_i_taken     in   1        resolved taken (1 for JAL/JALR)
//  cmt_i_pc        in   PC_SIZE  PC of the branch/jump
//  cmt_i_target    in   PC_SIZE  resolved taken target
//  flush_o_valid   out  1        redirect/flush request to IFU
//  flush_o_ready   in   1        IFU accepts redirect
//  flush_o_pc      out  PC_SIZE  redirect PC
//  busy_o          out  1        stage not IDLE
//  cnt_bjp_o       out  CNT_W    branches/jumps committed
//  cnt_mispred_o   out  CNT_W    mispredicts detected
// BEHAVIOUR
//  Reset: state=IDLE; flush_o_valid=0; flush_o_pc=0; drain cnt=0; both counters=0;
//   busy_o=0; cmt_i_ready=1 from first cycle after reset.
//  cmt_i_ready = (state==IDLE); purely from state, no combinational path from inputs.
//  Accept = cmt_i_valid & cmt_i_ready. Inputs ignored when not accepted.
//  On accept with cmt_i_bjp=1: cnt_bjp += 1 (saturate at all-ones).
//   mispredict = cmt_i_taken ^ cmt_i_bprdt. If set: cnt_mispred += 1 (saturate),
//   flush_o_pc <= cmt_i_taken ? cmt_i_target : cmt_i_pc + 4 (mod 2^PC_SIZE, wraps),
//   state <= REQ. Else state stays IDLE (back-to-back commits every cycle allowed).
//  On accept with cmt_i_bjp=0: no counter change, no flush; state stays IDLE.
//  FSM:
//   IDLE  : as above.
//   REQ   : flush_o_valid=1, flush_o_pc stable until accepted. On flush_o_ready:
//           DRAIN_CYC==0 -> IDLE; else drain cnt <= DRAIN_CYC, state <= DRAIN.
//           Without flush_o_ready: hold REQ indefinitely.
//   DRAIN : drain cnt decrements each cycle; when cnt==1 -> IDLE next edge.
//           Exactly DRAIN_CYC cycles in DRAIN with cmt_i_ready=0.
//  flush_o_valid is a registered output: asserted the cycle after the mispredict
//   accept, deasserted the cycle after handshake. Latency accept->flush = 1 cycle.
//  busy_o = (state!=IDLE).
//  Simultaneous events: cmt_i_valid during REQ/DRAIN is not accepted (ready=0);
//   upstream holds. flush_o_ready while IDLE/DRAIN is ignored.
//  Reset mid-operation (any state): return to IDLE same edge, pending flush dropped,
//   counters cleared.
//  Counters: CNT_W wide, saturate, never wrap; both may increment same cycle.
// TESTING
//  1 rst then bjp=1,bprdt=1,taken=1 every cycle x4 -> ready stays 1, cnt_bjp=4,
//    cnt_mispred=0, flush_o_valid never 1.
//  2 bjp=1,bprdt=0,taken=1,target=0x8000_0100 -> next cycle flush_o_valid=1,
//    flush_o_pc=0x8000_0100; ready=0 until flush done + 2 drain cycles.
//  3 bjp=1,bprdt=1,taken=0,pc=0xFFFF_FFFC -> flush_o_pc=0x0000_0000 (wrap);
//    hold flush_o_ready=0 for 5 cycles -> valid/pc stable; then ready=1 -> DRAIN 2, IDLE.
//  4 bjp=0 with bprdt!=taken -> no flush, counters unchanged; CNT_W=4 with 20
//    mispredicts -> both counters saturate at 15.
//  5 assert rst while in REQ and in DRAIN -> next cycle flush_o_valid=0, ready=1,
//    counters 0; DRAIN_CYC=0 build: flush accept -> ready=1 next cycle.

Source files
------------

// File: rtl/exu_bjp_cmt_if.sv
// exu_bjp_cmt_if: commit request from the BJP ALU and redirect request to the IFU.
interface exu_bjp_cmt_if #(parameter int PC_SIZE = 32);
   logic               cmt_i_valid;
   logic               cmt_i_ready;
   logic               cmt_i_bjp;
   logic               cmt_i_bprdt;
   logic               cmt_i_taken;
   logic [PC_SIZE-1:0] cmt_i_pc;
   logic [PC_SIZE-1:0] cmt_i_target;
   logic               flush_o_valid;
   logic               flush_o_ready;
   logic [PC_SIZE-1:0] flush_o_pc;
   modport master (
      output cmt_i_valid, cmt_i_bjp, cmt_i_bprdt, cmt_i_taken, cmt_i_pc, cmt_i_target, flush_o_ready,
      input  cmt_i_ready, flush_o_valid, flush_o_pc
   );
   modport slave (
      input  cmt_i_valid, cmt_i_bjp, cmt_i_bprdt, cmt_i_taken, cmt_i_pc, cmt_i_target, flush_o_ready,
      output cmt_i_ready, flush_o_valid, flush_o_pc
   );
endinterface

// File: rtl/exu_bjp_cmt.sv
// exu_bjp_cmt: branch/jump commit, mispredict redirect with drain window, perf counters.
module exu_bjp_cmt #(
   parameter int PC_SIZE   = 32,
   parameter int DRAIN_CYC = 2,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   exu_bjp_cmt_if.slave     bus,
   output logic             busy_o,
   output logic [CNT_W-1:0] cnt_bjp_o,
   output logic [CNT_W-1:0] cnt_mispred_o
);
   localparam int DW = DRAIN_CYC > 0 ? $clog2(DRAIN_CYC + 1) : 1;
   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
   state_t state_q, state_d;
   logic [DW-1:0] drain_q, drain_d;
   logic [PC_SIZE-1:0] pc_q, pc_d;
   logic [CNT_W-1:0] cnt_bjp_q, cnt_bjp_d, cnt_mis_q, cnt_mis_d;
   logic bjp_acc, mis_acc;
   assign bus.cmt_i_ready   = state_q == IDLE;
   assign bus.flush_o_valid = state_q == REQ;
   assign bus.flush_o_pc    = pc_q;
   assign busy_o            = state_q != IDLE;
   assign cnt_bjp_o         = cnt_bjp_q;
   assign cnt_mispred_o     = cnt_mis_q;
   assign bjp_acc = bus.cmt_i_valid & bus.cmt_i_ready & bus.cmt_i_bjp;
   assign mis_acc = bjp_acc & (bus.cmt_i_taken ^ bus.cmt_i_bprdt);
   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      pc_d      = pc_q;
      cnt_bjp_d = cnt_bjp_q + CNT_W'(bjp_acc & ~&cnt_bjp_q);
      cnt_mis_d = cnt_mis_q + CNT_W'(mis_acc & ~&cnt_mis_q);
      unique case (state_q)
         IDLE: if (mis_acc) begin
            pc_d    = bus.cmt_i_taken ? bus.cmt_i_target : bus.cmt_i_pc + PC_SIZE'(4);
            state_d = REQ;
         end
         REQ: if (bus.flush_o_ready) begin
            state_d = DRAIN_CYC == 0 ? IDLE : DRAIN;
            drain_d = DW'(DRAIN_CYC);
         end
         DRAIN: begin
            drain_d = drain_q - 1'b1;
            state_d = drain_q == DW'(1) ? IDLE : DRAIN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         drain_q   <= '0;
         pc_q      <= '0;
         cnt_bjp_q <= '0;
         cnt_mis_q <= '0;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         pc_q      <= pc_d;
         cnt_bjp_q <= cnt_bjp_d;
         cnt_mis_q <= cnt_mis_d;
      end
   end
endmodule

// File: tb/tb_exu_bjp_cmt.sv
// tb_exu_bjp_cmt: directed checks of the commit stage in default, CNT_W=4 and DRAIN_CYC=0 builds.
module tb_exu_bjp_cmt;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cmps = 0;
   int errs = 0;
   logic busy0, busy1, busy2;
   logic [31:0] cb0, cm0, cb2, cm2;
   logic [3:0] cb1, cm1;
   exu_bjp_cmt_if #(.PC_SIZE(32)) b0 ();
   exu_bjp_cmt_if #(.PC_SIZE(32)) b1 ();
   exu_bjp_cmt_if #(.PC_SIZE(32)) b2 ();
   exu_bjp_cmt u0 (.clk(clk), .rst(rst), .bus(b0), .busy_o(busy0), .cnt_bjp_o(cb0), .cnt_mispred_o(cm0));
   exu_bjp_cmt #(.CNT_W(4)) u1 (.clk(clk), .rst(rst), .bus(b1), .busy_o(busy1), .cnt_bjp_o(cb1), .cnt_mispred_o(cm1));
   exu_bjp_cmt #(.DRAIN_CYC(0)) u2 (.clk(clk), .rst(rst), .bus(b2), .busy_o(busy2), .cnt_bjp_o(cb2), .cnt_mispred_o(cm2));
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic bjp, input logic bp, input logic tk, input logic [31:0] pc, input logic [31:0] tg);
      b0.cmt_i_valid = v; b0.cmt_i_bjp = bjp; b0.cmt_i_bprdt = bp; b0.cmt_i_taken = tk;
      b0.cmt_i_pc = pc; b0.cmt_i_target = tg;
   endtask

   task automatic test_reset();
      drive0(0, 0, 0, 0, 0, 0); b0.flush_o_ready = 0;
      b1.cmt_i_valid = 0; b1.cmt_i_bjp = 0; b1.cmt_i_bprdt = 0; b1.cmt_i_taken = 0;
      b1.cmt_i_pc = 0; b1.cmt_i_target = 0; b1.flush_o_ready = 0;
      b2.cmt_i_valid = 0; b2.cmt_i_bjp = 0; b2.cmt_i_bprdt = 0; b2.cmt_i_taken = 0;
      b2.cmt_i_pc = 0; b2.cmt_i_target = 0; b2.flush_o_ready = 0;
      rst = 1; step(); step(); rst = 0;
      cmps++; if ({b0.cmt_i_ready, b0.flush_o_valid, busy0} !== 3'b100) begin
         $display("FAIL reset_ctl: ready/valid/busy=%b want 100", {b0.cmt_i_ready, b0.flush_o_valid, busy0}); errs++; end
      cmps++; if ({b0.flush_o_pc, cb0, cm0} !== 96'h0) begin
         $display("FAIL reset_regs: pc=%h bjp=%0d mis=%0d want 0", b0.flush_o_pc, cb0, cm0); errs++; end
   endtask

   task automatic test_predicted();
      for (int i = 0; i < 4; i++) begin
         drive0(1, 1, 1, 1, 32'h100 + 32'(i * 4), 32'h2000);
         step();
         cmps++; if ({b0.cmt_i_ready, b0.flush_o_valid} !== 2'b10) begin
            $display("FAIL pred_ready_%0d: ready/valid=%b want 10", i, {b0.cmt_i_ready, b0.flush_o_valid}); errs++; end
      end
      drive0(0, 0, 0, 0, 0, 0);
      cmps++; if (cb0 !== 32'd4 || cm0 !== 32'd0) begin
         $display("FAIL pred_cnt: bjp=%0d mis=%0d want 4/0", cb0, cm0); errs++; end
   endtask

   task automatic test_mispred_taken();
      b0.flush_o_ready = 1;
      drive0(1, 1, 0, 1, 32'h8000_0000, 32'h8000_0100);
      step(); drive0(0, 0, 0, 0, 0, 0);
      cmps++; if ({b0.flush_o_valid, b0.cmt_i_ready, busy0} !== 3'b101 || b0.flush_o_pc !== 32'h8000_0100) begin
         $display("FAIL mt_req: valid/ready/busy=%b pc=%h want 101 80000100", {b0.flush_o_valid, b0.cmt_i_ready, busy0}, b0.flush_o_pc); errs++; end
      step();
      cmps++; if ({b0.flush_o_valid, b0.cmt_i_ready} !== 2'b00) begin
         $display("FAIL mt_drain1: valid/ready=%b want 00", {b0.flush_o_valid, b0.cmt_i_ready}); errs++; end
      step();
      cmps++; if ({b0.flush_o_valid, b0.cmt_i_ready} !== 2'b00) begin
         $display("FAIL mt_drain2: valid/ready=%b want 00", {b0.flush_o_valid, b0.cmt_i_ready}); errs++; end
      step();
      cmps++; if ({b0.cmt_i_ready, busy0} !== 2'b10 || cb0 !== 32'd5 || cm0 !== 32'd1) begin
         $display("FAIL mt_idle: ready/busy=%b bjp=%0d mis=%0d want 10 5/1", {b0.cmt_i_ready, busy0}, cb0, cm0); errs++; end
      b0.flush_o_ready = 0;
   endtask

   task automatic test_mispred_wrap_hold();
      drive0(1, 1, 1, 0, 32'hFFFF_FFFC, 32'h0000_1234);
      step();
      drive0(1, 1, 0, 1, 32'h4000, 32'h5000);
      for (int i = 0; i < 5; i++) begin
         cmps++; if (b0.flush_o_valid !== 1'b1 || b0.flush_o_pc !== 32'h0 || b0.cmt_i_ready !== 1'b0) begin
            $display("FAIL wrap_hold_%0d: valid=%b pc=%h ready=%b want 1 00000000 0", i, b0.flush_o_valid, b0.flush_o_pc, b0.cmt_i_ready); errs++; end
         step();
      end
      b0.flush_o_ready = 1;
      step(); b0.flush_o_ready = 0;
      cmps++; if ({b0.flush_o_valid, b0.cmt_i_ready, busy0} !== 3'b001) begin
         $display("FAIL wrap_drain1: valid/ready/busy=%b want 001", {b0.flush_o_valid, b0.cmt_i_ready, busy0}); errs++; end
      step();
      cmps++; if (b0.cmt_i_ready !== 1'b0) begin
         $display("FAIL wrap_drain2: ready=%b want 0", b0.cmt_i_ready); errs++; end
      step(); drive0(0, 0, 0, 0, 0, 0);
      cmps++; if (b0.cmt_i_ready !== 1'b1 || cb0 !== 32'd6 || cm0 !== 32'd2) begin
         $display("FAIL wrap_idle: ready=%b bjp=%0d mis=%0d want 1 6/2", b0.cmt_i_ready, cb0, cm0); errs++; end
   endtask

   task automatic test_non_bjp();
      b0.flush_o_ready = 1;
      drive0(1, 0, 0, 1, 32'h300, 32'h400);
      step(); drive0(0, 0, 0, 0, 0, 0);
      cmps++; if ({b0.flush_o_valid, b0.cmt_i_ready} !== 2'b01 || cb0 !== 32'd6 || cm0 !== 32'd2) begin
         $display("FAIL non_bjp: valid/ready=%b bjp=%0d mis=%0d want 01 6/2", {b0.flush_o_valid, b0.cmt_i_ready}, cb0, cm0); errs++; end
      b0.flush_o_ready = 0;
   endtask

   task automatic test_saturate();
      int n;
      b1.flush_o_ready = 1;
      b1.cmt_i_valid = 1; b1.cmt_i_bjp = 1; b1.cmt_i_bprdt = 0; b1.cmt_i_taken = 1; b1.cmt_i_target = 32'h10;
      for (int i = 0; i < 20; i++) begin
         n = 0;
         while (b1.cmt_i_ready !== 1'b1 && n < 10) begin step(); n++; end
         cmps++; if (n >= 10) begin $display("FAIL sat_wait_%0d: ready=%b want 1 within 10 cycles", i, b1.cmt_i_ready); errs++; end
         step();
      end
      b1.cmt_i_valid = 0;
      for (int i = 0; i < 4; i++) step();
      cmps++; if (cb1 !== 4'd15 || cm1 !== 4'd15 || b1.cmt_i_ready !== 1'b1) begin
         $display("FAIL saturate: bjp=%0d mis=%0d ready=%b want 15/15 1", cb1, cm1, b1.cmt_i_ready); errs++; end
      b1.flush_o_ready = 0;
   endtask

   task automatic test_reset_mid();
      drive0(1, 1, 0, 1, 32'h700, 32'h900);
      step(); drive0(0, 0, 0, 0, 0, 0);
      cmps++; if (b0.flush_o_valid !== 1'b1) begin $display("FAIL rm_req: valid=%b want 1", b0.flush_o_valid); errs++; end
      rst = 1; step(); rst = 0;
      cmps++; if ({b0.flush_o_valid, b0.cmt_i_ready, busy0} !== 3'b010 || cb0 !== 32'd0 || cm0 !== 32'd0) begin
         $display("FAIL rm_req_rst: valid/ready/busy=%b bjp=%0d mis=%0d want 010 0/0", {b0.flush_o_valid, b0.cmt_i_ready, busy0}, cb0, cm0); errs++; end
      b0.flush_o_ready = 1;
      drive0(1, 1, 1, 0, 32'h800, 32'h900);
      step(); drive0(0, 0, 0, 0, 0, 0);
      step(); b0.flush_o_ready = 0;
      cmps++; if ({b0.cmt_i_ready, busy0} !== 2'b01) begin $display("FAIL rm_drain: ready/busy=%b want 01", {b0.cmt_i_ready, busy0}); errs++; end
      rst = 1; step(); rst = 0;
      cmps++; if ({b0.flush_o_valid, b0.cmt_i_ready, busy0} !== 3'b010 || cb0 !== 32'd0 || cm0 !== 32'd0) begin
         $display("FAIL rm_drain_rst: valid/ready/busy=%b bjp=%0d mis=%0d want 010 0/0", {b0.flush_o_valid, b0.cmt_i_ready, busy0}, cb0, cm0); errs++; end
   endtask

   task automatic test_no_drain();
      b2.flush_o_ready = 1;
      b2.cmt_i_valid = 1; b2.cmt_i_bjp = 1; b2.cmt_i_bprdt = 1; b2.cmt_i_taken = 0;
      b2.cmt_i_pc = 32'h1000; b2.cmt_i_target = 32'h2000;
      step(); b2.cmt_i_valid = 0;
      cmps++; if (b2.flush_o_valid !== 1'b1 || b2.flush_o_pc !== 32'h1004) begin
         $display("FAIL nd_req: valid=%b pc=%h want 1 00001004", b2.flush_o_valid, b2.flush_o_pc); errs++; end
      step();
      cmps++; if ({b2.flush_o_valid, b2.cmt_i_ready, busy2} !== 3'b010) begin
         $display("FAIL nd_idle: valid/ready/busy=%b want 010", {b2.flush_o_valid, b2.cmt_i_ready, busy2}); errs++; end
   endtask

   initial begin
      test_reset();
      test_predicted();
      test_mispred_taken();
      test_mispred_wrap_hold();
      test_non_bjp();
      test_saturate();
      test_reset_mid();
      test_no_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end
endmodule
